// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO read-side UART frame serialiser (optional parity via FIFO_UART_TX_PARITY_EN)
module fifo_uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EMPTY,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  R_INC,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef FIFO_UART_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;

`ifdef FIFO_UART_TX_PARITY_EN
    logic par_en_q;
    logic par_bit;
`else
    logic unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
`endif

    // Pop only when a new frame may start: idle, or the stop bit of the previous frame.
    assign R_INC = ~EMPTY & ((state == S_IDLE) | (state == S_STOP));

    // Frame sequencer; TX_OUT and BUSY are registered alongside the state they describe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            TX_OUT  <= 1'b1;
            BUSY    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_en_q <= 1'b0;
            par_bit  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_STOP: begin
                    if (R_INC) begin
                        shreg  <= RD_DATA;
`ifdef FIFO_UART_TX_PARITY_EN
                        // Parity is resolved at pop so later PAR_* changes cannot leak in.
                        par_en_q <= PAR_EN;
                        par_bit  <= (^RD_DATA) ^ PAR_TYP;
`endif
                        state  <= S_START;
                        TX_OUT <= 1'b0;
                        BUSY   <= 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        TX_OUT <= 1'b1;
                        BUSY   <= 1'b0;
                    end
                end
                S_START: begin
                    state   <= S_DATA;
                    bit_cnt <= '0;
                    TX_OUT  <= shreg[0];
                    shreg   <= shreg >> 1;
                end
                S_DATA: begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state  <= S_PARITY;
                            TX_OUT <= par_bit;
                        end else begin
                            state  <= S_STOP;
                            TX_OUT <= 1'b1;
                        end
`else
                        state  <= S_STOP;
                        TX_OUT <= 1'b1;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        TX_OUT  <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                S_PARITY: begin
                    state  <= S_STOP;
                    TX_OUT <= 1'b1;
                end
`endif
                default: begin
                    state  <= S_IDLE;
                    TX_OUT <= 1'b1;
                    BUSY   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx
module tb_fifo_uart_tx;

    localparam int DW = 8;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        bit            par_en;
        bit            par_typ;
        bit            exp_par;
    } vec_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          EMPTY = 1'b1;
    logic [DW-1:0] RD_DATA = '0;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          R_INC;
    logic          TX_OUT;
    logic          BUSY;

    int            tests = 0;
    int            fails = 0;
    int            pops  = 0;
    logic [DW-1:0] fifo_q[$];
    bit            exp_q[$];
    logic          pop_seen = 1'b0;
    vec_t          vecs[8];

    fifo_uart_tx #(.DATA_WIDTH(DW)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EMPTY   (EMPTY),
        .RD_DATA (RD_DATA),
        .R_INC   (R_INC),
        .PAR_EN  (PAR_EN),
        .PAR_TYP (PAR_TYP),
        .TX_OUT  (TX_OUT),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) pop_seen <= R_INC & ~RST;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void refresh();
        EMPTY   = (fifo_q.size() == 0);
        RD_DATA = EMPTY ? '0 : fifo_q[0];
    endfunction

    task automatic push_word(input logic [DW-1:0] d, input bit pe, input bit ep);
        fifo_q.push_back(d);
        refresh();
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
        if (PAR_BUILT && pe) exp_q.push_back(ep);
        exp_q.push_back(1'b1);
    endtask

    task automatic tick();
        @(negedge CLK);
        if (!RST) begin
            if (pop_seen) begin
                pops++;
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                refresh();
            end
            if (BUSY) begin
                if (exp_q.size() == 0) check("extra_frame_bit", 1, 0);
                else check("tx_bit", {31'b0, TX_OUT}, {31'b0, exp_q.pop_front()});
            end else begin
                check("idle_tx_high", {31'b0, TX_OUT}, 1);
            end
            check("r_inc_while_empty", {31'b0, R_INC & EMPTY}, 0);
        end
    endtask

    task automatic run_frame(input int exp_len, input int exp_pops, input bit flip, input int p0);
        int waited = 0;
        int run = 0;
        while (!BUSY && waited < 20) begin
            tick();
            waited++;
        end
        check("busy_seen", {31'b0, BUSY}, 1);
        if (flip) begin
            PAR_EN  = ~PAR_EN;
            PAR_TYP = ~PAR_TYP;
        end
        while (BUSY && run < 100) begin
            run++;
            tick();
        end
        check("busy_len", run, exp_len);
        check("pop_count", pops - p0, exp_pops);
        check("frame_drained", exp_q.size(), 0);
    endtask

    initial begin
        int p0;
        int waited;
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{8'h80, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{8'h3C, 1'b0, 1'b1, 1'b0};

        refresh();
        RST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check("rst_tx", {31'b0, TX_OUT}, 1);
            check("rst_busy", {31'b0, BUSY}, 0);
            check("rst_r_inc", {31'b0, R_INC}, 0);
        end
        RST = 1'b0;
        repeat (3) tick();

        for (int v = 0; v < 8; v++) begin
            p0      = pops;
            PAR_EN  = vecs[v].par_en;
            PAR_TYP = vecs[v].par_typ;
            push_word(vecs[v].data, vecs[v].par_en, vecs[v].exp_par);
            run_frame((PAR_BUILT && vecs[v].par_en) ? 11 : 10, 1, 1'b1, p0);
            repeat (2) tick();
        end

        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        p0 = pops;
        push_word(8'h01, 1'b0, 1'b0);
        push_word(8'h02, 1'b0, 1'b0);
        push_word(8'h03, 1'b0, 1'b0);
        run_frame(30, 3, 1'b0, p0);
        repeat (3) tick();

        p0 = pops;
        push_word(8'h55, 1'b0, 1'b0);
        waited = 0;
        while (!BUSY && waited < 20) begin
            tick();
            waited++;
        end
        check("busy_before_rst", {31'b0, BUSY}, 1);
        repeat (4) tick();
        #2 RST = 1'b1;
        #1;
        check("async_rst_tx", {31'b0, TX_OUT}, 1);
        check("async_rst_busy", {31'b0, BUSY}, 0);
        check("pop_0x55", pops - p0, 1);
        exp_q.delete();
        push_word(8'h3C, 1'b0, 1'b0);
        repeat (3) tick();
        RST = 1'b0;
        p0 = pops;
        run_frame(10, 1, 1'b0, p0);
        repeat (12) tick();
        check("fifo_empty_end", fifo_q.size(), 0);
        check("no_resend", pops - p0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
